// File: rtl/writeback_unit.sv
// Register-file write master: merges ALU results and queued load results.
// Optional same-cycle load bypass when WB_BYPASS_EN is defined.
module writeback_unit #(
   parameter int DATA_WIDTH      = 32,
   parameter int REG_ADDR_WIDTH  = 5,
   parameter int LOAD_FIFO_DEPTH = 4,
   localparam int NUM_REGS       = 2**REG_ADDR_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      alu_valid,
   input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0]     alu_data,
   input  logic                      lsu_valid,
   output logic                      lsu_ready,
   input  logic [REG_ADDR_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0]     lsu_data,
   output logic                      rf_we,
   output logic [REG_ADDR_WIDTH-1:0] rf_addr,
   output logic [DATA_WIDTH-1:0]     rf_data,
   output logic [NUM_REGS-1:0]       pending_mask,
   output logic                      wb_full
);

   localparam int PW = $clog2(LOAD_FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [REG_ADDR_WIDTH-1:0] q_rd   [LOAD_FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]     q_data [LOAD_FIFO_DEPTH];
   logic [LOAD_FIFO_DEPTH-1:0] q_live;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          out_load;

   logic full;
   logic empty;
   logic alu_w;
   logic hs;
   logic byp;
   logic push;
   logic pop;

   assign full      = (count == CW'(LOAD_FIFO_DEPTH));
   assign empty     = (count == '0);
   assign wb_full   = full;
   assign lsu_ready = !full;
   assign alu_w     = alu_valid && (alu_rd != '0);
   assign hs        = lsu_valid && lsu_ready;
`ifdef WB_BYPASS_EN
   assign byp       = hs && (lsu_rd != '0) && empty && !alu_w;
`else
   assign byp       = 1'b0;
`endif
   assign push      = hs && (lsu_rd != '0) && !byp;
   assign pop       = !alu_w && !empty;

   // Payload storage needs no reset; q_live tracks occupancy and kill state.
   always_ff @(posedge clk) begin
      if (push) begin
         q_rd[wr_ptr]   <= lsu_rd;
         q_data[wr_ptr] <= lsu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_live <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Older loads to the ALU's rd are superseded; the push below wins.
         for (int i = 0; i < LOAD_FIFO_DEPTH; i++) begin
            if (alu_w && (q_rd[i] == alu_rd)) q_live[i] <= 1'b0;
         end
         if (pop) begin
            q_live[rd_ptr] <= 1'b0;
            rd_ptr         <= rd_ptr + 1'b1;
         end
         if (push) begin
            q_live[wr_ptr] <= 1'b1;
            wr_ptr         <= wr_ptr + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_addr  <= '0;
         rf_data  <= '0;
         out_load <= 1'b0;
      end else begin
         unique case (1'b1)
            alu_w: begin
               rf_we    <= 1'b1;
               rf_addr  <= alu_rd;
               rf_data  <= alu_data;
               out_load <= 1'b0;
            end
            pop: begin
               rf_we    <= q_live[rd_ptr];
               rf_addr  <= q_rd[rd_ptr];
               rf_data  <= q_data[rd_ptr];
               out_load <= q_live[rd_ptr];
            end
            byp: begin
               rf_we    <= 1'b1;
               rf_addr  <= lsu_rd;
               rf_data  <= lsu_data;
               out_load <= 1'b1;
            end
            default: begin
               rf_we    <= 1'b0;
               out_load <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < LOAD_FIFO_DEPTH; i++) begin
         if (q_live[i]) pending_mask[q_rd[i]] = 1'b1;
      end
      if (rf_we && out_load) pending_mask[rf_addr] = 1'b1;
      pending_mask[0] = 1'b0;
   end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Write-side master for the core's 32x32 register file; sole driver of its write port (write enable, write address, write data).
- Merges two result streams, ALU (fixed-latency, no backpressure) and LSU loads (valid/ready), onto the single write port.
- ALU has priority; loads queue in a small FIFO.
- Exports a per-register pending mask so decode can stall on outstanding loads.

Parameters:
- DATA_WIDTH, 32, register data width
- REG_ADDR_WIDTH, 5, register index width; NUM_REGS = 2**REG_ADDR_WIDTH
- LOAD_FIFO_DEPTH, 4, load-result queue entries; power of two, >= 2

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- alu_valid  in  1  ALU result valid this cycle; always accepted
- alu_rd  in  REG_ADDR_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- lsu_valid  in  1  load result valid
- lsu_ready  out  1  load result accepted when lsu_valid & lsu_ready
- lsu_rd  in  REG_ADDR_WIDTH  load destination register
- lsu_data  in  DATA_WIDTH  load data
- rf_we  out  1  register file write enable
- rf_addr  out  REG_ADDR_WIDTH  register file write address
- rf_data  out  DATA_WIDTH  register file write data
- pending_mask  out  NUM_REGS  bit r = load to r queued or in output stage
- wb_full  out  1  FIFO full; pipeline must hold ALU issue until clear

Behaviour:
- Reset:
  - Synchronous: rf_we=0, rf_addr=0, rf_data=0.
  - FIFO emptied; pending_mask=0; wb_full=0.
  - lsu_ready=1 from the first cycle after rst deasserts.
  - rst asserted mid-operation discards all queued loads with no RF write.
- Output stage: rf_we/rf_addr/rf_data are registered; exactly one write per cycle max.
- ALU path:
  - alu_valid in cycle N with alu_rd!=0 gives rf_we=1, rf_addr=alu_rd, rf_data=alu_data in cycle N+1.
  - alu_rd==0: no write (rf_we=0 at N+1).
- Load path:
  - lsu_ready = !full, using the registered count. A pop in the same cycle does not re-open ready.
  - On a handshake with lsu_rd!=0, the entry {rd,data} is pushed.
  - On a handshake with lsu_rd==0, the result is accepted and discarded.
- Arbitration:
  - Each cycle: if alu_valid & alu_rd!=0, the ALU owns the output stage and the FIFO does not pop.
  - Otherwise, if the FIFO is non-empty, pop the head into the output stage.
  - Otherwise rf_we=0 next cycle.
- Latency: load pushed in N is written at N+2 at the earliest; each ALU-owned cycle adds one.
- Push/pop same cycle: both allowed; count unchanged; FIFO order preserved.
- Pointers: wrap modulo LOAD_FIFO_DEPTH; count width log2(DEPTH)+1.
- wb_full: equals (count==LOAD_FIFO_DEPTH). ALU results arriving while full are still honoured.
- WAW kill:
  - An ALU write to r (r!=0) accepted in cycle N clears the write-valid flag of every FIFO entry with rd==r.
  - Killed entries still pop in order but produce rf_we=0.
  - A load pushed in the same cycle N to the same r is NOT killed (it is younger).
- pending_mask:
  - Combinational OR of the decoded rd of every live (unkilled) FIFO entry, plus the output stage when it holds a load write.
  - Bit 0 is always 0.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: a load handshaking in cycle N while the FIFO is empty and no ALU write is claiming the stage goes straight to the output stage (write at N+1) and is not pushed.
  - Its pending bit is set during N+1 only.
  - lsu_ready is unchanged.
- Undefined: every load passes through the FIFO; minimum load latency is 2 cycles.

Test Plan:
- ALU writes: alu_valid, rd=5, data=0xDEADBEEF at cycle 10 -> rf_we=1, rf_addr=5, rf_data=0xDEADBEEF at cycle 11 only. Same with rd=0 -> rf_we stays 0.
- Collision: load rd=3 data=0x11 and ALU rd=4 data=0x22 both in cycle N -> RF gets x4=0x22 at N+1 and x3=0x11 at N+2. pending_mask[3]=1 over N+1..N+2.
- Backpressure: ALU valid (rd=1) every cycle while 5 loads are offered with DEPTH=4 -> lsu_ready=0 and wb_full=1 after the 4th push. Drop alu_valid -> queued loads drain in order, one per cycle, then ready returns.
- WAW kill: queue loads rd=7 (0xAA) then rd=8 (0xBB); ALU rd=7=0x55 next cycle -> only x7=0x55 and x8=0xBB are written. pending_mask[7] drops the cycle after the ALU write.
- Reset mid-queue: 3 loads queued, rst pulsed 1 cycle -> no further rf_we, pending_mask=0, lsu_ready=1 the next cycle.
- Bypass: with WB_BYPASS_EN defined, a lone load rd=2 at N -> write at N+1. Without it -> write at N+2.
